// File: rtl/bitscan_enc32to5_if.sv
// Handshake bundle for bitscan_enc32to5: vector input channel and index output channel.
interface bitscan_enc32to5_if;
  localparam int unsigned VEC_W = 32;
  localparam int unsigned IDX_W = 5;

  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] enc;
  logic             last;
  logic             zero_err;

  modport master (
    output in_valid, vec, out_ready,
    input  in_ready, out_valid, enc, last, zero_err
  );

  modport slave (
    input  in_valid, vec, out_ready,
    output in_ready, out_valid, enc, last, zero_err
  );
endinterface

// File: rtl/bitscan_enc32to5.sv
// Accepts a 32-bit request vector and emits the index of each set bit, one per cycle.
// Scan order is lowest-first by default; define BITSCAN_MSB_FIRST_EN for highest-first.
module bitscan_enc32to5 (
  input  logic                clk,
  input  logic                reset,
  bitscan_enc32to5_if.slave   bus
);
  localparam int unsigned VEC_W = 32;
  localparam int unsigned IDX_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] pending_q, pending_d;
  logic             zero_err_q, zero_err_d;
  logic [IDX_W-1:0] enc_c;
  logic             last_c;

  // Priority scan of the pending bits; the last match in loop order wins.
  always_comb begin : scan
    enc_c = '0;
`ifdef BITSCAN_MSB_FIRST_EN
    for (int i = 0; i < int'(VEC_W); i++) begin
      if (pending_q[i]) enc_c = IDX_W'(i);
    end
`else
    for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
      if (pending_q[i]) enc_c = IDX_W'(i);
    end
`endif
    last_c = (pending_q != '0) && ((pending_q & (pending_q - VEC_W'(1))) == '0);
  end

  always_comb begin : next_state
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.vec;
          if (bus.vec != '0) state_d = EMIT;
          else               zero_err_d = 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pending_d = pending_q & ~(VEC_W'(1) << enc_c);
          if (last_c) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.enc       = enc_c;
  assign bus.last      = last_c;
  assign bus.zero_err  = zero_err_q;
endmodule

// File: doc/bitscan_enc32to5.md
BITSCAN_ENC32TO5 -- requirements
Module: bitscan_enc32to5

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  vec is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-006 SHALL have port vec  input  32  request bit vector; bit i set means index i pending.
REQ-007 SHALL have port out_valid  output  1  enc holds a valid index.
REQ-008 SHALL have port out_ready  input  1  consumer accepts enc this cycle.
REQ-009 SHALL have port enc  output  5  binary index of the selected set bit.
REQ-010 SHALL have port last  output  1  enc is the final index of the current vector.
REQ-011 SHALL have port zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-012 SHALL implement FSM states IDLE and EMIT, plus a 32-bit pending register.
REQ-013 SHALL drive in_ready = 1 exactly when state is IDLE, and out_valid = 1 exactly when state is EMIT.
REQ-014 SHALL capture vec into pending on an input handshake (in_valid & in_ready) at rising edge k.
REQ-015 On that handshake, SHALL transition to EMIT when vec != 0, with out_valid high from cycle k+1.
REQ-016 On that handshake, SHALL stay in IDLE when vec == 0 and pulse zero_err for exactly cycle k+1.
REQ-017 SHALL derive enc combinationally from pending: the index of the lowest set bit (default scan order).
REQ-018 SHALL derive last combinationally: last = 1 iff pending has exactly one bit set.
REQ-019 SHALL drive enc = 0 and last = 0 whenever pending == 0.
REQ-020 On an output handshake (out_valid & out_ready) in EMIT, SHALL clear the bit indexed by enc in pending.
REQ-021 On an output handshake with last = 1, SHALL return to IDLE; otherwise SHALL remain in EMIT.
REQ-022 SHALL sustain throughput of one index per cycle while out_ready = 1.
REQ-023 SHALL insert exactly one idle (in_ready = 1) cycle between consecutive vectors.
REQ-024 Backpressure: while out_valid & !out_ready, SHALL hold enc, last and pending stable.
REQ-025 SHALL ignore in_valid and vec while in EMIT (no capture, no error).
REQ-026 Full vector (all 32 bits set) SHALL produce 32 indices, with last asserted only on the 32nd.

Reset
REQ-027 While reset = 1, SHALL hold state = IDLE, pending = 0, in_ready = 1, out_valid = 0, enc = 0, last = 0, zero_err = 0.
REQ-028 Reset asserted mid-EMIT SHALL immediately (asynchronously) drop out_valid and discard all remaining pending bits.
REQ-029 SHALL allow the first input handshake on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro BITSCAN_MSB_FIRST_EN SHALL select the scan order.
REQ-031 When BITSCAN_MSB_FIRST_EN is defined, enc SHALL be the index of the highest set bit in pending.
REQ-032 When BITSCAN_MSB_FIRST_EN is undefined, enc SHALL be the index of the lowest set bit in pending.
REQ-033 All other behaviour SHALL be identical in both builds.

Verification
REQ-034 Reset scenario: assert reset -> in_ready = 1, out_valid = 0, enc = 0, last = 0, zero_err = 0; pulse reset mid-EMIT -> out_valid = 0 without waiting for a clock edge.
REQ-035 Basic vector (default build): vec = 32'h8000_0011, out_ready held 1 -> enc = 0, 4, 31 on three consecutive cycles, last = 1 only with 31, then in_ready = 1.
REQ-036 Basic vector (BITSCAN_MSB_FIRST_EN build): vec = 32'h8000_0011, out_ready held 1 -> enc = 31, 4, 0, last = 1 only with 0.
REQ-037 Backpressure: vec = 32'h0000_0001 with out_ready = 0 for 3 cycles -> enc = 0, last = 1, out_valid held 3 cycles; out_ready = 1 -> IDLE on the next cycle.
REQ-038 Zero vector: vec = 32'h0000_0000 accepted -> zero_err = 1 for exactly one cycle, out_valid never asserts, in_ready stays 1.
REQ-039 Full vector: vec = 32'hFFFF_FFFF, out_ready = 1 -> enc = 0..31 on 32 consecutive cycles, last only with 31; in_valid pulsed during EMIT -> ignored.
